delay_sum_beamformer: RTL
=========================

DELAY_SUM_BEAMFORMER -- requirements
Module: delay_sum_beamformer

Parameters
REQ-001 SHALL have parameter NUM_LINES, default 2, meaning I2S data lines; each line carries a left and a right mic, so CH = 2*NUM_LINES channels; CH is a power of two.
REQ-002 SHALL have parameter SAMPLE_BITS, default 16, meaning the PCM width, two's complement, MSB first.
REQ-003 SHALL have parameter HALF_FRAME, default 32, meaning clk cycles per WS half, with HALF_FRAME >= SAMPLE_BITS+1.
REQ-004 SHALL have parameter DEPTH, default 16, meaning delay buffer depth per channel; DW = clog2(DEPTH); SUM_W = SAMPLE_BITS+clog2(CH).

Interface
REQ-005 SHALL have port clk, input, 1, meaning the single clock and the I2S bit clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port sd_in, input, NUM_LINES, meaning I2S serial data, one bit per line.
REQ-008 SHALL have port ws, output, 1, meaning generated word select: 0 = left half, 1 = right half.
REQ-009 SHALL have port cfg_we, input, 1, meaning config write strobe.
REQ-010 SHALL have port cfg_addr, input, clog2(CH), meaning channel select: ch 2i = left of line i, ch 2i+1 = right.
REQ-011 SHALL have port cfg_delay, input, DW, meaning delay in frames.
REQ-012 SHALL have port cfg_en, input, 1, meaning channel enable.
REQ-013 SHALL have port sum_out, output, SUM_W, meaning the registered signed delay-and-sum result.
REQ-014 SHALL have port sum_valid, output, 1, meaning a one-cycle strobe when sum_out updates.
REQ-015 SHALL have port sout, output, 1, meaning I2S serial output of the averaged sum, mono, sent in both halves.

Function
REQ-016 SHALL run frame counter cnt over 0..2*HALF_FRAME-1 with wrap; ws = (cnt >= HALF_FRAME); frame_tick = (cnt == 2*HALF_FRAME-1).
REQ-017 SHALL capture the sd_in bit at cnt = k (left) and at cnt = HALF_FRAME+k (right), for k = 1..SAMPLE_BITS, MSB at k=1; other bits SHALL be ignored.
REQ-018 SHALL, on frame_tick, push each channel's completed sample into its DEPTH-entry shift buffer (entry 0 = newest) and discard the oldest.
REQ-019 SHALL hold cfg writes in shadow registers (delay, en); cfg_we with any cfg_addr value writes that channel's shadow.
REQ-020 SHALL copy shadow to active registers on frame_tick; a write in the frame_tick cycle itself SHALL take effect at the following frame_tick.
REQ-021 SHALL treat an active delay >= DEPTH as DEPTH-1 (clamp).
REQ-022 SHALL, in the cycle with cnt == 0, register sum_out = signed sum over enabled channels of buffer[ch][delay[ch]], each sign-extended to SUM_W; disabled channels SHALL contribute 0.
REQ-023 SHALL assert sum_valid for exactly one cycle, at cnt == 1, i.e. 2 cycles after frame_tick.
REQ-024 SHALL not overflow: the SUM_W sizing is exact; no saturation logic.
REQ-025 SHALL, when sum_valid is high, load avg = sum_out arithmetically shifted right by clog2(CH), truncated to SAMPLE_BITS, into a transmit register.
REQ-026 SHALL, from the next frame, drive sout = avg bit SAMPLE_BITS-k at cnt = k and at cnt = HALF_FRAME+k (k = 1..SAMPLE_BITS), and drive 0 elsewhere.
REQ-027 SHALL drive sout with the transmit register as loaded; a new load SHALL not corrupt bits of the frame in progress, since the load occurs at cnt = 1 and is used from the next cnt = 1.

Reset
REQ-028 SHALL, with reset high on a clk edge: cnt=0, ws=0, all buffers=0, shadow/active delay=0, en=1 for all channels, sum_out=0, sum_valid=0, tx register=0, sout=0.
REQ-029 SHALL abort any partially received sample when reset is asserted mid-frame; the first frame_tick SHALL occur 2*HALF_FRAME-1 cycles after reset deasserts.

Verification (NUM_LINES=2, SAMPLE_BITS=16, HALF_FRAME=32, DEPTH=12, SUM_W=18)
- Reset 3 cycles, then release: ws=0, sum_out=0, sout=0; first sum_valid at cycle 65 after release; ws rises at cycle 32.
- All delays 0, both lines send L=0x1000, R=0x0100: sum_out=0x02200, avg=0x0880 on sout MSB-first in both halves of the following frame.
- All four channels send 0xFFFF: sum_out=0x3FFFC (-4), avg=0xFFFF.
- ch0 delay=3, impulse 0x7FFF on ch0 in frame 5 only, others 0: sum_out=0x07FFF only for frame 8's sum, 0 otherwise.
- cfg_we on the frame_tick cycle setting ch1 en=0: the next sum still includes ch1; the sum after that excludes it.
- cfg_delay=15 on ch2 with impulse: behaves as delay 11; reset asserted at cnt=40: sum_valid is suppressed and cnt restarts at 0.

Source files
------------

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer for I2S microphone arrays: deserialises CH mics,
// delays each channel by a whole number of frames, sums and re-serialises the average.
module delay_sum_beamformer #(
  parameter int NUM_LINES   = 2,
  parameter int SAMPLE_BITS = 16,
  parameter int HALF_FRAME  = 32,
  parameter int DEPTH       = 16
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_LINES-1:0]                           sd_in,
  output logic                                           ws,
  input  logic                                           cfg_we,
  input  logic [$clog2(2*NUM_LINES)-1:0]                 cfg_addr,
  input  logic [$clog2(DEPTH)-1:0]                       cfg_delay,
  input  logic                                           cfg_en,
  output logic [SAMPLE_BITS+$clog2(2*NUM_LINES)-1:0]     sum_out,
  output logic                                           sum_valid,
  output logic                                           sout
);

  localparam int CH    = 2 * NUM_LINES;
  localparam int CH_W  = $clog2(CH);
  localparam int DW    = $clog2(DEPTH);
  localparam int SUM_W = SAMPLE_BITS + CH_W;
  localparam int FRAME = 2 * HALF_FRAME;
  localparam int CNT_W = $clog2(FRAME);

  localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] HALF_C     = CNT_W'(HALF_FRAME);
  localparam logic [CNT_W-1:0] SB_C       = CNT_W'(SAMPLE_BITS);
  localparam logic [CNT_W-1:0] RIGHT_LO_C = CNT_W'(HALF_FRAME + 1);
  localparam logic [CNT_W-1:0] RIGHT_HI_C = CNT_W'(HALF_FRAME + SAMPLE_BITS);

  logic [CNT_W-1:0]       cnt;
  logic                   frame_tick;
  logic                   tick_d;
  logic                   in_left;
  logic                   in_right;
  logic [CNT_W-1:0]       bit_k;
  logic                   tx_bit;

  logic [SAMPLE_BITS-1:0] left_sr     [NUM_LINES];
  logic [SAMPLE_BITS-1:0] right_sr    [NUM_LINES];
  logic [SAMPLE_BITS-1:0] done_sample [CH];
  logic [SAMPLE_BITS-1:0] dbuf        [CH][DEPTH];

  logic [DW-1:0]          shadow_delay [CH];
  logic [DW-1:0]          active_delay [CH];
  logic [CH-1:0]          shadow_en;
  logic [CH-1:0]          active_en;

  logic [SUM_W-1:0]       sum_next;
  logic [SAMPLE_BITS-1:0] tx_reg;
  logic [SAMPLE_BITS-1:0] tx_active;

  // Delays beyond the buffer read the oldest entry instead of wrapping.
  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
    if (int'(d) > DEPTH - 1) return DW'(DEPTH - 1);
    return d;
  endfunction

  function automatic logic [SUM_W-1:0] sign_ext(input logic [SAMPLE_BITS-1:0] s);
    return {{CH_W{s[SAMPLE_BITS-1]}}, s};
  endfunction

  assign frame_tick = (cnt == LAST_C);
  assign ws         = (cnt >= HALF_C);
  assign in_left    = (cnt != '0) && (cnt <= SB_C);
  assign in_right   = (cnt >= RIGHT_LO_C) && (cnt <= RIGHT_HI_C);
  assign bit_k      = in_right ? (cnt - HALF_C) : cnt;

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      done_sample[2*i]   = left_sr[i];
      done_sample[2*i+1] = right_sr[i];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum_next = '0;
    for (int c = 0; c < CH; c++) begin
      if (active_en[c]) sum_next = sum_next + sign_ext(dbuf[c][clamp_delay(active_delay[c])]);
    end
  end

  // Bit k of each half carries avg bit SAMPLE_BITS-k, MSB first.
  always_comb begin
    tx_bit = 1'b0;
    for (int b = 0; b < SAMPLE_BITS; b++) begin
      if (bit_k == CNT_W'(SAMPLE_BITS - b)) tx_bit = tx_active[b];
    end
  end

  assign sout = (in_left || in_right) && tx_bit;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      tick_d    <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      tx_reg    <= '0;
      tx_active <= '0;
      shadow_en <= '1;
      active_en <= '1;
      for (int i = 0; i < NUM_LINES; i++) begin
        left_sr[i]  <= '0;
        right_sr[i] <= '0;
      end
      // NOTE: the delay buffers are flops, not RAM, so clearing them on reset is intended.
      for (int c = 0; c < CH; c++) begin
        shadow_delay[c] <= '0;
        active_delay[c] <= '0;
        for (int d = 0; d < DEPTH; d++) dbuf[c][d] <= '0;
      end
    end else begin
      cnt    <= frame_tick ? '0 : cnt + CNT_W'(1);
      tick_d <= frame_tick;

      for (int i = 0; i < NUM_LINES; i++) begin
        if (in_left)  left_sr[i]  <= {left_sr[i][SAMPLE_BITS-2:0], sd_in[i]};
        if (in_right) right_sr[i] <= {right_sr[i][SAMPLE_BITS-2:0], sd_in[i]};
      end

      if (cfg_we) begin
        shadow_delay[cfg_addr] <= cfg_delay;
        shadow_en[cfg_addr]    <= cfg_en;
      end

      // Active config reads the old shadow, so a same-cycle write waits one frame.
      if (frame_tick) begin
        active_en <= shadow_en;
        tx_active <= tx_reg;
        for (int c = 0; c < CH; c++) begin
          active_delay[c] <= shadow_delay[c];
          dbuf[c][0]      <= done_sample[c];
          for (int d = 1; d < DEPTH; d++) dbuf[c][d] <= dbuf[c][d-1];
        end
      end

      sum_valid <= tick_d;
      if (tick_d) sum_out <= sum_next;

      // Arithmetic shift by CH_W then truncation is exactly the top SAMPLE_BITS bits.
      if (sum_valid) tx_reg <= sum_out[SUM_W-1:CH_W];
    end
  end

endmodule
